// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-to-1 valid/ready stream multiplexer with a single registered
// output stage. Selects either a fixed channel (sel) or arbitrates round-robin,
// and tags each output beat with the channel it came from.
//
// Handshake: a beat moves on any interface at a rising clk edge where valid
// and ready are both 1. in_ready is combinational and may depend on in_valid
// (round-robin); producers must not make in_valid depend on in_ready. out_valid
// stays high with out_data/out_ch stable until out_ready accepts the beat.
module rr_stream_mux #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  // Round-robin pointer: channel searched first on the next arbitration.
  logic [SEL_W-1:0]  ptr;
  logic              load_en;
  logic [SEL_W-1:0]  grant;
  logic              grant_ok;
  logic [DATA_W-1:0] grant_data;
  logic              xfer;

  // The output register can take a new beat when empty or being drained.
  assign load_en = !out_valid || out_ready;

  // Candidate channel: sel in fixed mode, else first valid channel from ptr.
  always_comb begin
    int best_d;
    int d;
    grant    = '0;
    grant_ok = 1'b0;
    best_d   = NUM_CH;
    d        = 0;
    if (!mode) begin
      if (int'(sel) < NUM_CH) begin
        grant    = sel;
        grant_ok = 1'b1;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // Distance of channel i from ptr in search order.
        d = i - int'(ptr);
        if (d < 0) d = d + NUM_CH;
        if (in_valid[i] && d < best_d) begin
          best_d   = d;
          grant    = SEL_W'(i);
          grant_ok = 1'b1;
        end
      end
    end
  end

  // Only the candidate channel sees ready, and only when the stage can load.
  always_comb begin
    in_ready = '0;
    if (rst_n && grant_ok && load_en) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(grant) == i) in_ready[i] = 1'b1;
      end
    end
  end

  // Data of the candidate channel.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(grant) == i) grant_data = in_data[i*DATA_W +: DATA_W];
    end
  end

  assign xfer = |(in_ready & in_valid);

  // Output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant;
      if (mode) begin
        ptr <= (int'(grant) == NUM_CH - 1) ? '0 : grant + SEL_W'(1);
      end
    end else if (out_ready) begin
      // Drain: data and channel keep their last value.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Testbench for rr_stream_mux: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_rr_stream_mux;

  localparam int N  = 4;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          mode;
  logic [1:0]    sel;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    out_ch;
  logic          out_valid;
  logic          out_ready;

  // Three-channel instance for the out-of-range select case.
  logic          mode3;
  logic [1:0]    sel3;
  logic [3*DW-1:0] in_data3;
  logic [2:0]    in_valid3;
  logic [2:0]    in_ready3;
  logic [DW-1:0] out_data3;
  logic [1:0]    out_ch3;
  logic          out_valid3;
  logic          out_ready3;

  rr_stream_mux #(.NUM_CH(N), .DATA_W(DW), .SEL_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  rr_stream_mux #(.NUM_CH(3), .DATA_W(DW), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];

  // Reference model: the beat held at the output and the next channel to favour.
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  int            m_ch    = 0;
  int            m_ptr   = 0;
  logic [N-1:0]  exp_ready;
  bit            m_xfer;
  int            m_xch;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Which channel the rules say is offered ready this cycle, and whether it moves.
  task automatic model_eval();
    bit le;
    int c;
    exp_ready = '0;
    m_xfer    = 1'b0;
    m_xch     = 0;
    if (rst_n) begin
      le = !m_valid || out_ready;
      if (!mode) begin
        if (int'(sel) < N && le) exp_ready[sel] = 1'b1;
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (in_valid[c]) begin
            if (le) exp_ready[c] = 1'b1;
            break;
          end
        end
      end
      for (int j = 0; j < N; j++) begin
        if (exp_ready[j] && in_valid[j]) begin
          m_xfer = 1'b1;
          m_xch  = j;
        end
      end
    end
  endtask

  task automatic model_update();
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_ch    = 0;
      m_ptr   = 0;
    end else if (m_xfer) begin
      m_valid = 1'b1;
      m_data  = in_data[m_xch*DW +: DW];
      m_ch    = m_xch;
      if (mode) m_ptr = (m_xch + 1) % N;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: compare everything at negedge, advance model at posedge.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_data", 32'(out_data), 32'(m_data));
    chk("out_ch", 32'(out_ch), 32'(m_ch));
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst_n = 1'b0; mode = 1'b1; sel = 2'd0; in_valid = 4'hF;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11}; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b000; in_data3 = '0; out_ready3 = 1'b1;
    @(posedge clk); #1;

    // Reset with all channels valid
    cycle();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_ch", 32'(out_ch), 32'h0);
    cycle();
    rst_n = 1'b1; #1;
    chk("rr_first_ready", 32'(in_ready), 32'h1);
    cycle();
    chk("rr_first_ch", 32'(out_ch), 32'h0);

    // Fixed select of channel 2
    mode = 1'b0; sel = 2'd2; in_data = {8'h44, 8'hA5, 8'h22, 8'h11}; #1;
    chk("fix_ready", 32'(in_ready), 32'b0100);
    cycle();
    chk("fix_data", 32'(out_data), 32'hA5);
    chk("fix_ch", 32'(out_ch), 32'h2);
    chk("fix_valid", 32'(out_valid), 32'h1);
    for (int i = 0; i < 3; i++) begin
      in_data[23:16] = 8'($urandom);
      cycle();
      chk("fix_stream", 32'(out_data), 32'(in_data[23:16]));
    end

    // Reset in the middle of a held beat, then round-robin fairness
    rst_n = 1'b0;
    cycle();
    chk("midrst_valid", 32'(out_valid), 32'h0);
    rst_n = 1'b1; mode = 1'b1; in_valid = 4'hF;
    for (int i = 0; i < 8; i++) exp_q.push_back(2'(i % N));
    for (int i = 0; i < 8; i++) begin
      in_data = $urandom;
      cycle();
      chk("rr_seq", 32'(out_ch), 32'(exp_q.pop_front()));
    end

    // Round-robin skip over idle channels
    in_valid = 4'b0001;
    cycle();
    in_valid = 4'b1001;
    cycle();
    chk("skip_a", 32'(out_ch), 32'h3);
    cycle();
    chk("skip_b", 32'(out_ch), 32'h0);
    cycle();
    chk("skip_c", 32'(out_ch), 32'h3);

    // Backpressure on a held beat
    mode = 1'b0; sel = 2'd1; in_valid = 4'hF; in_data[15:8] = 8'h3C;
    cycle();
    out_ready = 1'b0; #1;
    chk("bp_ready", 32'(in_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      in_data[15:8] = 8'($urandom);
      cycle();
      chk("bp_data", 32'(out_data), 32'h3C);
      chk("bp_ch", 32'(out_ch), 32'h1);
    end
    in_data[15:8] = 8'h5A; out_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(in_ready), 32'b0010);
    cycle();
    chk("bp_reload_valid", 32'(out_valid), 32'h1);
    chk("bp_reload_data", 32'(out_data), 32'h5A);
    in_valid = 4'h0;
    cycle();
    chk("drain_valid", 32'(out_valid), 32'h0);
    chk("drain_data", 32'(out_data), 32'h5A);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom_range(0, 3));
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rst_n = 1'b1;
    cycle();

    // Out-of-range select on the three-channel instance
    sel3 = 2'd1; in_valid3 = 3'b111; in_data3 = {8'h99, 8'h77, 8'h55}; out_ready3 = 1'b0; #1;
    chk("oor_sel1_ready", 32'(in_ready3), 32'b010);
    @(posedge clk); #1;
    chk("oor_load_valid", 32'(out_valid3), 32'h1);
    chk("oor_load_data", 32'(out_data3), 32'h77);
    chk("oor_load_ch", 32'(out_ch3), 32'h1);
    sel3 = 2'd3; out_ready3 = 1'b1; #1;
    chk("oor_ready", 32'(in_ready3), 32'h0);
    @(posedge clk); #1;
    chk("oor_drain_valid", 32'(out_valid3), 32'h0);
    chk("oor_drain_ch", 32'(out_ch3), 32'h1);
    chk("oor_idle_ready", 32'(in_ready3), 32'h0);
    @(posedge clk); #1;
    chk("oor_stay_empty", 32'(out_valid3), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
Name:
rr_stream_mux

Overview:
Parametrised N-to-1 streaming multiplexer: the registered, handshaked successor of the combinational 4:1 select function.
- Forwards one beat per cycle from NUM_CH valid/ready input channels to a single registered output channel.
- Two selection modes: fixed select (external sel) or round-robin arbitration.
- Sits between per-channel producers and a single downstream consumer. Reports the source channel of each output beat.

Parameters:
NUM_CH, 4, number of input channels (2..16)
DATA_W, 8, data width per channel
SEL_W, 2, width of sel/out_ch; must equal clog2(NUM_CH), minimum 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
mode  input  1  0 = fixed select via sel, 1 = round-robin
sel  input  SEL_W  channel index in fixed mode; ignored in round-robin
in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
in_valid  input  NUM_CH  per-channel valid
in_ready  output  NUM_CH  per-channel ready (combinational)
out_data  output  DATA_W  registered output data
out_ch  output  SEL_W  source channel of the current out_data
out_valid  output  1  output valid (registered)
out_ready  input  1  downstream ready

Behaviour:
- Interface: one clock (clk); synchronous, active-low reset (rst_n). All state updates on the rising edge of clk.
- Reset (rst_n=0 at a clock edge): out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
  - in_ready is forced to all-zero while rst_n=0.
  - A beat held in the output register is discarded.
- Load enable: load_en = !out_valid || out_ready. Single output stage, so full throughput is 1 beat/cycle.
- Fixed mode (mode=0):
  - Candidate = sel. in_ready[sel] = load_en; all other bits are 0.
  - If sel >= NUM_CH, no channel is selected and in_ready is all-zero.
- Round-robin mode (mode=1):
  - Search channels ptr, ptr+1, ..., wrapping modulo NUM_CH. The first channel with in_valid=1 is the grant g.
  - in_ready[g] = load_en; all other bits are 0. If no channel is valid, in_ready is all-zero.
  - in_ready may depend on in_valid; in_valid must not depend on in_ready.
- Transfer on channel c: in_valid[c] && in_ready[c] at a clock edge. Next cycle: out_data = channel c data, out_ch = c, out_valid = 1. Latency is exactly 1 cycle.
- Pointer update:
  - On a round-robin transfer from g: ptr <= (g+1) mod NUM_CH. Wraps from NUM_CH-1 to 0.
  - ptr is unchanged in fixed mode and on cycles without a transfer.
- Output hold: while out_valid && !out_ready, out_data and out_ch stay stable and no channel is ready.
- Drain: out_ready=1 with no input transfer -> out_valid <= 0. out_data and out_ch keep their last value.
- Simultaneous drain and load (out_valid && out_ready and an input transfer): the new beat replaces the old one; out_valid stays 1.
- mode/sel changes:
  - Take effect combinationally in the same cycle for in_ready.
  - Never alter a beat already held in the output register.
  - Switching modes leaves ptr untouched.
- Reset mid-operation: the in-flight output beat is lost. The first cycle with rst_n=1 behaves as post-reset (ptr=0).

Test Plan:
- Reset: rst_n=0 for 2 cycles, all in_valid=1 -> in_ready=0000, out_valid=0, out_data=0, out_ch=0. After release, round-robin grants ch0 first.
- Fixed select: mode=0, sel=2, in_data ch2=0xA5, in_valid=1111, out_ready=1 -> in_ready=0100. Next cycle out_data=0xA5, out_ch=2, out_valid=1. One beat per cycle while held.
- Round-robin fairness: mode=1, in_valid=1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3; wrap from 3 to 0 verified.
- Round-robin skip: mode=1, ptr=1, in_valid=1001 -> grant ch3, then ptr=0 -> grant ch0, then ch3.
- Backpressure: out_ready=0 with out_valid=1, out_data=0x3C -> in_ready=0000 and out_data/out_ch stable for 5 cycles. Raising out_ready gives drain and load in the same cycle, out_valid stays 1.
- Out-of-range select with NUM_CH=3 (SEL_W=2): mode=0, sel=3 -> in_ready=000, out_valid falls to 0 after the pending beat drains.
